// File: rtl/debug_wr_sequencer_if.sv
// Bus bundle for debug_wr_sequencer: core-side push port plus the AXI-lite write channels
// toward the debug slave. The master modport is the sequencer's view; the slave modport is
// the view of whatever sits on the other side (core hook and debug slave together).
interface debug_wr_sequencer_if;
  logic        push_valid;
  logic        push_ready;
  logic [1:0]  push_kind;
  logic [7:0]  push_data;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    input  push_valid, push_kind, push_data, awready, wready, bresp, bvalid,
    output push_ready, awaddr, awvalid, wdata, wstrb, wvalid, bready
  );

  modport slave (
    output push_valid, push_kind, push_data, awready, wready, bresp, bvalid,
    input  push_ready, awaddr, awvalid, wdata, wstrb, wvalid, bready
  );
endinterface

// File: rtl/debug_wr_sequencer.sv
// debug_wr_sequencer: buffers debug-peripheral requests (UART char, timer start/stop,
// finish) in a FIFO and issues them one at a time as AXI-lite writes (AW and W together).
// Optional watchdog on a stuck transaction is enabled by defining DBG_SEQ_TIMEOUT_EN.
module debug_wr_sequencer #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  debug_wr_sequencer_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  input  logic                 err_clr,
  output logic [15:0]          sent_cnt,
  output logic                 timeout
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
  } req_t;

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  req_t            mem_q [FIFO_DEPTH];
  req_t            mem_d [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push_ready_q, push_ready_d;
  state_e          state_q, state_d;
  logic [31:0]     awaddr_q, awaddr_d;
  logic            awvalid_q, awvalid_d;
  logic [63:0]     wdata_q, wdata_d;
  logic [7:0]      wstrb_q, wstrb_d;
  logic            wvalid_q, wvalid_d;
  logic            bready_q, bready_d;
  logic [1:0]      kind_q, kind_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [15:0]     sent_cnt_q, sent_cnt_d;

  logic            push_fire;
  logic            pop;
  logic            bresp_err;
  logic            tmo_set;
  logic            timeout_q;
  req_t            head;

  assign head = mem_q[rd_ptr_q];

  // FIFO bookkeeping, pop/load of holding registers and the write FSM.
  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    state_d      = state_q;
    awaddr_d     = awaddr_q;
    awvalid_d    = awvalid_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    kind_d       = kind_q;
    done_d       = done_q;
    sent_cnt_d   = sent_cnt_q;
    bresp_err    = 1'b0;
    pop          = 1'b0;
    push_fire    = bus.push_valid & push_ready_q;

    unique case (state_q)
      StIdle: begin
        // DONE freezes the queue: entries stay but nothing more is issued.
        if ((count_q != '0) && !done_q) begin
          pop       = 1'b1;
          kind_d    = head.kind;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = StReq;
          unique case (head.kind)
            2'd0: begin
              awaddr_d = BASE_ADDR;
              wdata_d  = {56'b0, head.data};
              wstrb_d  = 8'h01;
            end
            2'd1: begin
              awaddr_d = BASE_ADDR + 32'd8;
              wdata_d  = 64'd1;
              wstrb_d  = 8'hFF;
            end
            2'd2: begin
              awaddr_d = BASE_ADDR + 32'd8;
              wdata_d  = 64'd0;
              wstrb_d  = 8'hFF;
            end
            default: begin
              awaddr_d = BASE_ADDR + 32'd16;
              wdata_d  = 64'd1;
              wstrb_d  = 8'hFF;
            end
          endcase
        end
      end
      StReq: begin
        // AW and W handshakes complete independently, in either order.
        if (awvalid_q && bus.awready) awvalid_d = 1'b0;
        if (wvalid_q && bus.wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = StResp;
          bready_d = 1'b1;
        end
      end
      StResp: begin
        if (bus.bvalid) begin
          sent_cnt_d = sent_cnt_q + 16'd1;
          bresp_err  = (bus.bresp != 2'b00);
          if (kind_q == 2'd3) done_d = 1'b1;
          bready_d   = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (push_fire) begin
      mem_d[wr_ptr_q] = '{kind: bus.push_kind, data: bus.push_data};
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);

    unique case ({push_fire, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    // Registered ready reflects next-cycle fullness, so a freed slot is offered one cycle later.
    push_ready_d = (count_d != CntW'(FIFO_DEPTH));
  end

`ifdef DBG_SEQ_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

  logic [TmoW-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_d;

  // Watchdog counts cycles spent in REQ/RESP; it only flags, the transaction carries on.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    tmo_set  = 1'b0;
    if ((state_q == StIdle) || (state_d == StIdle)) begin
      wd_cnt_d = '0;
    end else if (wd_cnt_q != TmoW'(TIMEOUT_CYC)) begin
      wd_cnt_d = wd_cnt_q + TmoW'(1);
      tmo_set  = (wd_cnt_d == TmoW'(TIMEOUT_CYC));
    end
    timeout_d = tmo_set ? 1'b1 : (err_clr ? 1'b0 : timeout_q);
  end

  // Watchdog state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end
`else
  assign tmo_set   = 1'b0;
  assign timeout_q = 1'b0;
`endif

  // Sticky error: a new error in the same cycle as err_clr wins.
  always_comb begin
    err_d = (bresp_err || tmo_set) ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  // All sequencer state; reset abandons any in-flight write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      push_ready_q <= 1'b0;
      state_q      <= StIdle;
      awaddr_q     <= '0;
      awvalid_q    <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      kind_q       <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      sent_cnt_q   <= '0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      push_ready_q <= push_ready_d;
      state_q      <= state_d;
      awaddr_q     <= awaddr_d;
      awvalid_q    <= awvalid_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      kind_q       <= kind_d;
      done_q       <= done_d;
      err_q        <= err_d;
      sent_cnt_q   <= sent_cnt_d;
    end
  end

  assign bus.push_ready = push_ready_q;
  assign bus.awaddr     = awaddr_q;
  assign bus.awvalid    = awvalid_q;
  assign bus.wdata      = wdata_q;
  assign bus.wstrb      = wstrb_q;
  assign bus.wvalid     = wvalid_q;
  assign bus.bready     = bready_q;
  assign busy           = (count_q != '0) || (state_q != StIdle);
  assign done           = done_q;
  assign err            = err_q;
  assign sent_cnt       = sent_cnt_q;
  assign timeout        = timeout_q;

endmodule

// File: tb/tb_debug_wr_sequencer.sv
// Directed bench for debug_wr_sequencer: one task per scenario, inline comparisons.
module tb_debug_wr_sequencer;

  localparam logic [31:0] Base = 32'h2000_0000;
`ifdef DBG_SEQ_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push_valid = 1'b0;
  logic [1:0]  push_kind = 2'd0;
  logic [7:0]  push_data = 8'd0;
  logic        awready_r = 1'b0;
  logic        wready_r = 1'b0;
  logic        bvalid_r = 1'b0;
  logic [1:0]  bresp_r = 2'b00;
  logic        auto_b = 1'b0;
  logic        err_clr = 1'b0;
  logic        busy, done, err, timeout;
  logic [15:0] sent_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] aw_q[$];
  logic [63:0] wd_q[$];
  logic [7:0]  ws_q[$];

  debug_wr_sequencer_if bus ();

  assign bus.push_valid = push_valid;
  assign bus.push_kind  = push_kind;
  assign bus.push_data  = push_data;
  assign bus.awready    = awready_r;
  assign bus.wready     = wready_r;
  assign bus.bresp      = bresp_r;
  assign bus.bvalid     = auto_b ? bus.bready : bvalid_r;

  debug_wr_sequencer #(
    .FIFO_DEPTH (8),
    .BASE_ADDR  (Base),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.master),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .err_clr (err_clr),
    .sent_cnt(sent_cnt),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // Capture every completed AW and W handshake.
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.awvalid && bus.awready) aw_q.push_back(bus.awaddr);
      if (bus.wvalid && bus.wready) begin
        wd_q.push_back(bus.wdata);
        ws_q.push_back(bus.wstrb);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  task automatic clear_log();
    aw_q.delete();
    wd_q.delete();
    ws_q.delete();
  endtask

  task automatic push(input logic [1:0] k, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    push_valid = 1'b1;
    push_kind  = k;
    push_data  = d;
    while (!bus.push_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.push_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL push_accept: push_ready=%0b after %0d cycles, required 1", bus.push_ready, n);
    end
    @(posedge clk);
    #1;
    push_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 600) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_idle: busy=%0b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_log();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.push_ready, bus.awvalid, bus.wvalid, bus.bready, busy, done, err, timeout} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, required 00000000",
               {bus.push_ready, bus.awvalid, bus.wvalid, bus.bready, busy, done, err, timeout});
    end
    n_cmp++;
    if ({sent_cnt, bus.awaddr, bus.wstrb} !== 56'h0) begin
      n_fail++;
      $display("FAIL reset_regs: sent_cnt=%h awaddr=%h wstrb=%h, required 0", sent_cnt, bus.awaddr,
               bus.wstrb);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.push_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: push_ready=%0b, required 1", bus.push_ready);
    end
  endtask

  task automatic test_uart_char();
    awready_r = 1'b1;
    wready_r  = 1'b1;
    auto_b    = 1'b1;
    bresp_r   = 2'b00;
    clear_log();
    push(2'd0, 8'h41);
    @(negedge clk);
    n_cmp++;
    if (bus.awvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL uart_latency_early: awvalid=%0b at t+1, required 0", bus.awvalid);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.awvalid, bus.wvalid} !== 2'b11) begin
      n_fail++;
      $display("FAIL uart_latency: awvalid,wvalid=%b at t+2, required 11", {bus.awvalid, bus.wvalid});
    end
    n_cmp++;
    if ({bus.awaddr, bus.wdata, bus.wstrb} !== {32'h2000_0000, 64'h41, 8'h01}) begin
      n_fail++;
      $display("FAIL uart_payload: addr=%h data=%h strb=%h, required 20000000/41/01", bus.awaddr,
               bus.wdata, bus.wstrb);
    end
    wait_idle();
    n_cmp++;
    if ({sent_cnt, 32'(aw_q.size())} !== {16'd1, 32'd1}) begin
      n_fail++;
      $display("FAIL uart_count: sent_cnt=%0d aw_cnt=%0d, required 1/1", sent_cnt, aw_q.size());
    end
  endtask

  task automatic test_fifo_full();
    logic [15:0] base;
    logic [63:0] exp;
    base      = sent_cnt;
    awready_r = 1'b0;
    wready_r  = 1'b0;
    auto_b    = 1'b1;
    clear_log();
    push(2'd0, 8'h58);  // popped at once, then stalls in REQ
    for (int i = 0; i < 8; i++) push(2'd0, 8'h30 + 8'(i));
    @(negedge clk);
    n_cmp++;
    if ({bus.push_ready, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL fifo_full: push_ready,busy=%b, required 01", {bus.push_ready, busy});
    end
    fork
      push(2'd0, 8'h38);
      begin
        repeat (4) @(negedge clk);
        n_cmp++;
        if (bus.push_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL fifo_hold: push_ready=%0b while full, required 0", bus.push_ready);
        end
        awready_r = 1'b1;
        wready_r  = 1'b1;
      end
    join
    wait_idle();
    n_cmp++;
    if ({sent_cnt, 32'(wd_q.size())} !== {16'(base + 16'd10), 32'd10}) begin
      n_fail++;
      $display("FAIL fifo_count: sent_cnt=%0d writes=%0d, required %0d/10", sent_cnt, wd_q.size(),
               base + 16'd10);
    end
    for (int i = 0; i < 10; i++) begin
      exp = (i == 0) ? 64'h58 : 64'(8'h30 + 8'(i - 1));
      n_cmp++;
      if (wd_q[i] !== exp) begin
        n_fail++;
        $display("FAIL fifo_order[%0d]: wdata=%h, required %h", i, wd_q[i], exp);
      end
    end
  endtask

  task automatic test_w_before_aw();
    logic [15:0] base;
    base      = sent_cnt;
    awready_r = 1'b0;
    wready_r  = 1'b1;
    auto_b    = 1'b0;
    bvalid_r  = 1'b1;  // early B must be held off until RESP
    clear_log();
    push(2'd0, 8'h5A);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({bus.awvalid, bus.wvalid, bus.bready, sent_cnt} !== {3'b100, base}) begin
        n_fail++;
        $display("FAIL w_first[%0d]: aw,w,b=%b sent=%0d, required 100/%0d", i,
                 {bus.awvalid, bus.wvalid, bus.bready}, sent_cnt, base);
      end
      if (i < 2) @(negedge clk);
    end
    awready_r = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.awvalid, bus.bready} !== 2'b01) begin
      n_fail++;
      $display("FAIL w_first_resp: awvalid,bready=%b, required 01", {bus.awvalid, bus.bready});
    end
    @(negedge clk);
    bvalid_r = 1'b0;
    n_cmp++;
    if ({bus.bready, sent_cnt, 32'(aw_q.size())} !== {1'b0, 16'(base + 16'd1), 32'd1}) begin
      n_fail++;
      $display("FAIL w_first_done: bready=%0b sent=%0d aw_cnt=%0d, required 0/%0d/1", bus.bready,
               sent_cnt, aw_q.size(), base + 16'd1);
    end
    wready_r = 1'b1;
    auto_b   = 1'b1;
  endtask

  task automatic test_finish();
    logic [15:0] base;
    int n = 0;
    base      = sent_cnt;
    awready_r = 1'b1;
    wready_r  = 1'b1;
    auto_b    = 1'b1;
    bresp_r   = 2'b00;
    clear_log();
    push(2'd1, 8'h00);
    push(2'd2, 8'h00);
    push(2'd3, 8'h00);
    push(2'd0, 8'h71);
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    n_cmp++;
    if ({done, busy, bus.push_ready, bus.awvalid} !== 4'b1110) begin
      n_fail++;
      $display("FAIL finish_flags: done,busy,ready,awvalid=%b, required 1110",
               {done, busy, bus.push_ready, bus.awvalid});
    end
    n_cmp++;
    if ({sent_cnt, 32'(aw_q.size())} !== {16'(base + 16'd3), 32'd3}) begin
      n_fail++;
      $display("FAIL finish_count: sent=%0d writes=%0d, required %0d/3", sent_cnt, aw_q.size(),
               base + 16'd3);
    end
    n_cmp++;
    if ({aw_q[0], wd_q[0], ws_q[0]} !== {Base + 32'd8, 64'd1, 8'hFF}) begin
      n_fail++;
      $display("FAIL finish_tstart: %h/%h/%h, required %h/1/ff", aw_q[0], wd_q[0], ws_q[0],
               Base + 32'd8);
    end
    n_cmp++;
    if ({aw_q[1], wd_q[1], ws_q[1]} !== {Base + 32'd8, 64'd0, 8'hFF}) begin
      n_fail++;
      $display("FAIL finish_tstop: %h/%h/%h, required %h/0/ff", aw_q[1], wd_q[1], ws_q[1],
               Base + 32'd8);
    end
    n_cmp++;
    if ({aw_q[2], wd_q[2], ws_q[2]} !== {Base + 32'd16, 64'd1, 8'hFF}) begin
      n_fail++;
      $display("FAIL finish_cotrl: %h/%h/%h, required %h/1/ff", aw_q[2], wd_q[2], ws_q[2],
               Base + 32'd16);
    end
  endtask

  task automatic test_err();
    int n = 0;
    awready_r = 1'b1;
    wready_r  = 1'b1;
    auto_b    = 1'b1;
    bresp_r   = 2'b10;
    push(2'd0, 8'h45);
    wait_idle();
    n_cmp++;
    if ({err, done, sent_cnt} !== {2'b10, 16'd1}) begin
      n_fail++;
      $display("FAIL err_set: err=%0b done=%0b sent=%0d, required 1/0/1", err, done, sent_cnt);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_cmp++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clr: err=%0b, required 0", err);
    end
    // Hold err_clr through a failing response: the set must win on that edge.
    err_clr = 1'b1;
    push(2'd0, 8'h46);
    while (sent_cnt != 16'd2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if ({err, sent_cnt} !== {1'b1, 16'd2}) begin
      n_fail++;
      $display("FAIL err_set_wins: err=%0b sent=%0d, required 1/2", err, sent_cnt);
    end
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clr_after: err=%0b, required 0", err);
    end
    err_clr = 1'b0;
    bresp_r = 2'b00;
    push(2'd0, 8'h47);
    wait_idle();
    n_cmp++;
    if ({err, sent_cnt} !== {1'b0, 16'd3}) begin
      n_fail++;
      $display("FAIL err_okay: err=%0b sent=%0d, required 0/3", err, sent_cnt);
    end
  endtask

  task automatic test_reset_mid_req();
    awready_r = 1'b0;
    wready_r  = 1'b0;
    push(2'd0, 8'h61);
    push(2'd0, 8'h62);
    @(negedge clk);
    n_cmp++;
    if ({bus.awvalid, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL midreq_setup: awvalid,busy=%b, required 11", {bus.awvalid, busy});
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.awvalid, bus.wvalid, busy, bus.push_ready, sent_cnt} !== {4'b0000, 16'd0}) begin
      n_fail++;
      $display("FAIL midreq_async: aw,w,busy,ready=%b sent=%0d, required 0000/0",
               {bus.awvalid, bus.wvalid, busy, bus.push_ready}, sent_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.push_ready, busy, bus.awvalid} !== 3'b100) begin
      n_fail++;
      $display("FAIL midreq_after: ready,busy,awvalid=%b, required 100",
               {bus.push_ready, busy, bus.awvalid});
    end
    clear_log();
  endtask

  task automatic test_timeout();
    logic [15:0] base;
    int n = 0;
    base      = sent_cnt;
    awready_r = 1'b1;
    wready_r  = 1'b1;
    auto_b    = 1'b0;
    bvalid_r  = 1'b0;
    bresp_r   = 2'b00;
    push(2'd0, 8'h54);
    @(negedge clk);
    while (!bus.awvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (15) @(negedge clk);
    n_cmp++;
    if ({timeout, err} !== 2'b00) begin
      n_fail++;
      $display("FAIL tmo_early: timeout,err=%b after 15 cycles, required 00", {timeout, err});
    end
    @(negedge clk);
    n_cmp++;
    if ({timeout, err, bus.bready} !== {TmoEn, TmoEn, 1'b1}) begin
      n_fail++;
      $display("FAIL tmo_fire: timeout,err,bready=%b after 16 cycles, required %b%b1",
               {timeout, err, bus.bready}, TmoEn, TmoEn);
    end
    bvalid_r = 1'b1;
    @(negedge clk);
    bvalid_r = 1'b0;
    n_cmp++;
    if ({sent_cnt, busy} !== {16'(base + 16'd1), 1'b0}) begin
      n_fail++;
      $display("FAIL tmo_late_b: sent=%0d busy=%0b, required %0d/0", sent_cnt, busy, base + 16'd1);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_cmp++;
    if ({timeout, err} !== 2'b00) begin
      n_fail++;
      $display("FAIL tmo_clr: timeout,err=%b, required 00", {timeout, err});
    end
  endtask

  initial begin
    test_reset();
    test_uart_char();
    test_fifo_full();
    test_w_before_aw();
    test_finish();
    do_reset();
    test_err();
    test_reset_mid_req();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
